// File: rtl/tlb_access_arbiter_sv32.sv
// Single-port access arbiter in front of a shared cva6_tlb_sv32.
// One TLB operation per cycle, in priority order: flush, starvation-forced
// lookup, PTW update, round-robin I/D lookup. Lookup results are registered
// and returned to the owning requester one cycle after the grant.
// Optional hit/miss performance counters: define TLB_ARB_PERF_CNT_EN.
module tlb_access_arbiter_sv32 #(
  parameter int unsigned ASID_WIDTH   = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // instruction-fetch lookup port
  input  logic                  i_req_valid_i,
  output logic                  i_req_ready_o,
  input  logic [31:0]           i_vaddr_i,
  input  logic [ASID_WIDTH-1:0] i_asid_i,
  output logic                  i_rsp_valid_o,
  output logic                  i_rsp_hit_o,
  output logic [31:0]           i_rsp_content_o,
  output logic                  i_rsp_is_4M_o,
  // load/store lookup port
  input  logic                  d_req_valid_i,
  output logic                  d_req_ready_o,
  input  logic [31:0]           d_vaddr_i,
  input  logic [ASID_WIDTH-1:0] d_asid_i,
  output logic                  d_rsp_valid_o,
  output logic                  d_rsp_hit_o,
  output logic [31:0]           d_rsp_content_o,
  output logic                  d_rsp_is_4M_o,
  // page-table-walker update port
  input  logic                  ptw_upd_valid_i,
  output logic                  ptw_upd_ready_o,
  input  logic [61:0]           ptw_upd_i,
  // SFENCE.VMA flush request
  input  logic                  flush_req_i,
  input  logic [ASID_WIDTH-1:0] flush_asid_i,
  input  logic [31:0]           flush_vaddr_i,
  output logic                  flush_done_o,
  // TLB side
  output logic                  tlb_flush_o,
  output logic [62:0]           tlb_update_o,
  output logic                  tlb_lu_access_o,
  output logic [ASID_WIDTH-1:0] tlb_lu_asid_o,
  output logic [31:0]           tlb_lu_vaddr_o,
  output logic [ASID_WIDTH-1:0] tlb_asid_to_be_flushed_o,
  output logic [31:0]           tlb_vaddr_to_be_flushed_o,
  input  logic [31:0]           tlb_lu_content_i,
  input  logic                  tlb_lu_hit_i,
`ifdef TLB_ARB_PERF_CNT_EN
  output logic [31:0]           perf_hit_cnt_o,
  output logic [31:0]           perf_miss_cnt_o,
`endif
  input  logic                  tlb_lu_is_4M_i
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {OP_IDLE, OP_FLUSH, OP_UPD, OP_LU} op_e;
  typedef enum logic {PORT_I, PORT_D} port_e;

  logic                  flush_pend;
  logic [ASID_WIDTH-1:0] flush_asid_q;
  logic [31:0]           flush_vaddr_q;
  port_e                 rr_ptr;
  logic [CNT_W-1:0]      starve_cnt;

  op_e   op;
  port_e lu_sel;
  logic  lu_pend;
  logic  lu_both;
  logic  lu_block;
  logic  i_grant;
  logic  d_grant;

  // Pick this cycle's single TLB operation; nothing is issued while in reset.
  always_comb begin
    op       = OP_IDLE;
    lu_pend  = i_req_valid_i | d_req_valid_i;
    lu_both  = i_req_valid_i & d_req_valid_i;
    // A flush request seen this cycle already blocks lookups: it issues next cycle.
    lu_block = flush_pend | flush_req_i;
    if (lu_both) begin
      lu_sel = rr_ptr;
    end else if (d_req_valid_i) begin
      lu_sel = PORT_D;
    end else begin
      lu_sel = PORT_I;
    end
    if (!rst_ni) begin
      op = OP_IDLE;
    end else if (flush_pend) begin
      op = OP_FLUSH;
    end else if (lu_pend && !lu_block && (starve_cnt == CNT_MAX)) begin
      op = OP_LU;
    end else if (ptw_upd_valid_i) begin
      op = OP_UPD;
    end else if (lu_pend && !lu_block) begin
      op = OP_LU;
    end
  end

  assign i_grant = (op == OP_LU) && (lu_sel == PORT_I);
  assign d_grant = (op == OP_LU) && (lu_sel == PORT_D);

  // TLB-side drive: every field is zero unless its operation is issued.
  always_comb begin
    i_req_ready_o             = i_grant;
    d_req_ready_o             = d_grant;
    ptw_upd_ready_o           = (op == OP_UPD);
    tlb_flush_o               = (op == OP_FLUSH);
    tlb_update_o              = '0;
    tlb_lu_access_o           = (op == OP_LU);
    tlb_lu_asid_o             = '0;
    tlb_lu_vaddr_o            = '0;
    tlb_asid_to_be_flushed_o  = '0;
    tlb_vaddr_to_be_flushed_o = '0;
    if (op == OP_UPD) begin
      tlb_update_o = {1'b1, ptw_upd_i};
    end
    if (i_grant) begin
      tlb_lu_asid_o  = i_asid_i;
      tlb_lu_vaddr_o = i_vaddr_i;
    end else if (d_grant) begin
      tlb_lu_asid_o  = d_asid_i;
      tlb_lu_vaddr_o = d_vaddr_i;
    end
    if (op == OP_FLUSH) begin
      tlb_asid_to_be_flushed_o  = flush_asid_q;
      tlb_vaddr_to_be_flushed_o = flush_vaddr_q;
    end
  end

  // Flush capture: back-to-back requests merge, newest fields win.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flush_pend    <= 1'b0;
      flush_asid_q  <= '0;
      flush_vaddr_q <= '0;
      flush_done_o  <= 1'b0;
    end else begin
      flush_done_o <= (op == OP_FLUSH);
      if (flush_req_i) begin
        flush_pend    <= 1'b1;
        flush_asid_q  <= flush_asid_i;
        flush_vaddr_q <= flush_vaddr_i;
      end else if (op == OP_FLUSH) begin
        flush_pend <= 1'b0;
      end
    end
  end

  // Round-robin pointer and lookup starvation counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr     <= PORT_I;
      starve_cnt <= '0;
    end else begin
      if ((op == OP_LU) && lu_both) begin
        rr_ptr <= (lu_sel == PORT_I) ? PORT_D : PORT_I;
      end
      if ((op == OP_LU) || !lu_pend) begin
        starve_cnt <= '0;
      end else if ((op == OP_UPD) && (starve_cnt != CNT_MAX)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

  // Register the TLB result for the port that owned the lookup.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      i_rsp_valid_o   <= 1'b0;
      i_rsp_hit_o     <= 1'b0;
      i_rsp_content_o <= '0;
      i_rsp_is_4M_o   <= 1'b0;
      d_rsp_valid_o   <= 1'b0;
      d_rsp_hit_o     <= 1'b0;
      d_rsp_content_o <= '0;
      d_rsp_is_4M_o   <= 1'b0;
    end else begin
      i_rsp_valid_o <= i_grant;
      d_rsp_valid_o <= d_grant;
      if (i_grant) begin
        i_rsp_hit_o     <= tlb_lu_hit_i;
        i_rsp_content_o <= tlb_lu_content_i;
        i_rsp_is_4M_o   <= tlb_lu_is_4M_i;
      end
      if (d_grant) begin
        d_rsp_hit_o     <= tlb_lu_hit_i;
        d_rsp_content_o <= tlb_lu_content_i;
        d_rsp_is_4M_o   <= tlb_lu_is_4M_i;
      end
    end
  end

`ifdef TLB_ARB_PERF_CNT_EN
  logic rsp_any;
  logic rsp_hit;

  assign rsp_any = i_rsp_valid_o | d_rsp_valid_o;
  assign rsp_hit = i_rsp_valid_o ? i_rsp_hit_o : d_rsp_hit_o;

  // Hit/miss counters over delivered responses, cleared by each flush issue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_hit_cnt_o  <= '0;
      perf_miss_cnt_o <= '0;
    end else if (op == OP_FLUSH) begin
      perf_hit_cnt_o  <= '0;
      perf_miss_cnt_o <= '0;
    end else if (rsp_any) begin
      if (rsp_hit) begin
        perf_hit_cnt_o <= perf_hit_cnt_o + 32'd1;
      end else begin
        perf_miss_cnt_o <= perf_miss_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tlb_access_arbiter_sv32.sv
// Bench for tlb_access_arbiter_sv32: vector table, directed corner sequences,
// then random traffic against a behavioural arbiter model and a small TLB.
module tb_tlb_access_arbiter_sv32;

  localparam int AW = 1;
  localparam int SL = 4;

  logic          clk_i;
  logic          rst_ni;
  logic          i_req_valid_i, i_req_ready_o;
  logic [31:0]   i_vaddr_i;
  logic [AW-1:0] i_asid_i;
  logic          i_rsp_valid_o, i_rsp_hit_o, i_rsp_is_4M_o;
  logic [31:0]   i_rsp_content_o;
  logic          d_req_valid_i, d_req_ready_o;
  logic [31:0]   d_vaddr_i;
  logic [AW-1:0] d_asid_i;
  logic          d_rsp_valid_o, d_rsp_hit_o, d_rsp_is_4M_o;
  logic [31:0]   d_rsp_content_o;
  logic          ptw_upd_valid_i, ptw_upd_ready_o;
  logic [61:0]   ptw_upd_i;
  logic          flush_req_i;
  logic [AW-1:0] flush_asid_i;
  logic [31:0]   flush_vaddr_i;
  logic          flush_done_o;
  logic          tlb_flush_o;
  logic [62:0]   tlb_update_o;
  logic          tlb_lu_access_o;
  logic [AW-1:0] tlb_lu_asid_o;
  logic [31:0]   tlb_lu_vaddr_o;
  logic [AW-1:0] tlb_asid_to_be_flushed_o;
  logic [31:0]   tlb_vaddr_to_be_flushed_o;
  logic [31:0]   tlb_lu_content_i;
  logic          tlb_lu_hit_i;
  logic          tlb_lu_is_4M_i;

  tlb_access_arbiter_sv32 #(.ASID_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .i_req_valid_i(i_req_valid_i), .i_req_ready_o(i_req_ready_o),
    .i_vaddr_i(i_vaddr_i), .i_asid_i(i_asid_i),
    .i_rsp_valid_o(i_rsp_valid_o), .i_rsp_hit_o(i_rsp_hit_o),
    .i_rsp_content_o(i_rsp_content_o), .i_rsp_is_4M_o(i_rsp_is_4M_o),
    .d_req_valid_i(d_req_valid_i), .d_req_ready_o(d_req_ready_o),
    .d_vaddr_i(d_vaddr_i), .d_asid_i(d_asid_i),
    .d_rsp_valid_o(d_rsp_valid_o), .d_rsp_hit_o(d_rsp_hit_o),
    .d_rsp_content_o(d_rsp_content_o), .d_rsp_is_4M_o(d_rsp_is_4M_o),
    .ptw_upd_valid_i(ptw_upd_valid_i), .ptw_upd_ready_o(ptw_upd_ready_o),
    .ptw_upd_i(ptw_upd_i),
    .flush_req_i(flush_req_i), .flush_asid_i(flush_asid_i),
    .flush_vaddr_i(flush_vaddr_i), .flush_done_o(flush_done_o),
    .tlb_flush_o(tlb_flush_o), .tlb_update_o(tlb_update_o),
    .tlb_lu_access_o(tlb_lu_access_o), .tlb_lu_asid_o(tlb_lu_asid_o),
    .tlb_lu_vaddr_o(tlb_lu_vaddr_o),
    .tlb_asid_to_be_flushed_o(tlb_asid_to_be_flushed_o),
    .tlb_vaddr_to_be_flushed_o(tlb_vaddr_to_be_flushed_o),
    .tlb_lu_content_i(tlb_lu_content_i), .tlb_lu_hit_i(tlb_lu_hit_i),
    .tlb_lu_is_4M_i(tlb_lu_is_4M_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- small TLB environment (8 entries) ----------------
  logic        tv  [8];
  logic [19:0] tvpn[8];
  logic [8:0]  tas [8];
  logic [31:0] tc  [8];
  logic        t4  [8];
  int          tptr = 0;

  initial for (int k = 0; k < 8; k++) tv[k] = 1'b0;

  // The TLB answers whatever the arbiter presents; lowest index wins.
  always_comb begin
    tlb_lu_hit_i     = 1'b0;
    tlb_lu_content_i = '0;
    tlb_lu_is_4M_i   = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (tv[k] && (tas[k][AW-1:0] == tlb_lu_asid_o) &&
          (t4[k] ? (tvpn[k][19:10] == tlb_lu_vaddr_o[31:22]) : (tvpn[k] == tlb_lu_vaddr_o[31:12]))) begin
        tlb_lu_hit_i     = 1'b1;
        tlb_lu_content_i = tc[k];
        tlb_lu_is_4M_i   = t4[k];
      end
    end
  end

  task automatic tlb_ref(input logic [31:0] va, input logic [AW-1:0] as,
                         output logic h, output logic [31:0] c, output logic m);
    h = 1'b0; c = '0; m = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (tv[k] && (tas[k][AW-1:0] == as) &&
          (t4[k] ? (tvpn[k][19:10] == va[31:22]) : (tvpn[k] == va[31:12]))) begin
        h = 1'b1; c = tc[k]; m = t4[k];
      end
    end
  endtask

  task automatic env_write(input logic [61:0] u);
    int idx;
    idx = tptr;
    for (int k = 0; k < 8; k++)
      if (tv[k] && tvpn[k] == u[60:41] && tas[k] == u[40:32] && t4[k] == u[61]) idx = k;
    if (idx == tptr) tptr = (tptr + 1) % 8;
    tv[idx] = 1'b1; t4[idx] = u[61]; tvpn[idx] = u[60:41]; tas[idx] = u[40:32]; tc[idx] = u[31:0];
  endtask

  task automatic env_flush(input logic [AW-1:0] as, input logic [31:0] va);
    for (int k = 0; k < 8; k++) begin
      if (va == 0 && as == 0) tv[k] = 1'b0;
      else if (va == 0 && tas[k][AW-1:0] == as) tv[k] = 1'b0;
      else if (va != 0 && tvpn[k] == va[31:12] && (as == 0 || tas[k][AW-1:0] == as)) tv[k] = 1'b0;
    end
  endtask

  // ---------------- behavioural arbiter model ----------------
  bit            m_fp, m_done, m_iv, m_dv;
  logic [AW-1:0] m_fa;
  logic [31:0]   m_fv;
  int            m_rr, m_st;                 // m_rr: 0 = I preferred, 1 = D
  logic          m_ihit, m_i4m, m_dhit, m_d4m;
  logic [31:0]   m_icont, m_dcont;
  int            e_op, e_win;                // op: 0 idle, 1 flush, 2 update, 3 lookup
  bit            e_pend, e_both;
  logic [31:0]   e_va;
  logic [AW-1:0] e_as;

  task automatic model_reset();
    m_fp = 0; m_done = 0; m_iv = 0; m_dv = 0; m_fa = '0; m_fv = '0;
    m_rr = 0; m_st = 0;
    m_ihit = 0; m_i4m = 0; m_icont = '0; m_dhit = 0; m_d4m = 0; m_dcont = '0;
  endtask

  // Settle inputs driven at negedge, then compare every output with the model.
  task automatic settle();
    bit blk;
    logic [62:0] e_upd;
    #1;
    if (!rst_ni) model_reset();
    e_pend = i_req_valid_i || d_req_valid_i;
    e_both = i_req_valid_i && d_req_valid_i;
    blk    = m_fp || flush_req_i;
    e_win  = e_both ? m_rr : (d_req_valid_i ? 1 : 0);
    if (!rst_ni) e_op = 0;
    else if (m_fp) e_op = 1;
    else if (e_pend && !blk && m_st == SL) e_op = 3;
    else if (ptw_upd_valid_i) e_op = 2;
    else if (e_pend && !blk) e_op = 3;
    else e_op = 0;
    e_va  = (e_op == 3) ? (e_win == 1 ? d_vaddr_i : i_vaddr_i) : 32'h0;
    e_as  = (e_op == 3) ? (e_win == 1 ? d_asid_i : i_asid_i) : '0;
    e_upd = (e_op == 2) ? {1'b1, ptw_upd_i} : 63'h0;
    chk("i_req_ready", 64'(i_req_ready_o), 64'(e_op == 3 && e_win == 0));
    chk("d_req_ready", 64'(d_req_ready_o), 64'(e_op == 3 && e_win == 1));
    chk("ptw_upd_ready", 64'(ptw_upd_ready_o), 64'(e_op == 2));
    chk("tlb_flush", 64'(tlb_flush_o), 64'(e_op == 1));
    chk("tlb_update", 64'(tlb_update_o), 64'(e_upd));
    chk("tlb_lu_access", 64'(tlb_lu_access_o), 64'(e_op == 3));
    chk("tlb_lu_vaddr", 64'(tlb_lu_vaddr_o), 64'(e_va));
    chk("tlb_lu_asid", 64'(tlb_lu_asid_o), 64'(e_as));
    chk("flush_asid_out", 64'(tlb_asid_to_be_flushed_o), 64'(e_op == 1 ? m_fa : '0));
    chk("flush_vaddr_out", 64'(tlb_vaddr_to_be_flushed_o), 64'(e_op == 1 ? m_fv : 32'h0));
    chk("flush_done", 64'(flush_done_o), 64'(m_done));
    chk("i_rsp_valid", 64'(i_rsp_valid_o), 64'(m_iv));
    chk("d_rsp_valid", 64'(d_rsp_valid_o), 64'(m_dv));
    if (m_iv) chk("i_rsp_data", 64'({i_rsp_is_4M_o, i_rsp_hit_o, i_rsp_content_o}),
                  64'({m_i4m, m_ihit, m_icont}));
    if (m_dv) chk("d_rsp_data", 64'({d_rsp_is_4M_o, d_rsp_hit_o, d_rsp_content_o}),
                  64'({m_d4m, m_dhit, m_dcont}));
  endtask

  // Advance one clock: model and TLB environment take the cycle's effects.
  task automatic tick();
    logic h, m;
    logic [31:0] c;
    @(posedge clk_i);
    #1;
    if (rst_ni) begin
      m_iv = 0; m_dv = 0;
      if (e_op == 3) begin
        tlb_ref(e_va, e_as, h, c, m);
        if (e_win == 0) begin m_iv = 1; m_ihit = h; m_icont = c; m_i4m = m; end
        else            begin m_dv = 1; m_dhit = h; m_dcont = c; m_d4m = m; end
      end
      m_done = (e_op == 1);
      if (e_op == 2) env_write(ptw_upd_i);
      if (e_op == 1) env_flush(m_fa, m_fv);
      if (flush_req_i) begin m_fp = 1; m_fa = flush_asid_i; m_fv = flush_vaddr_i; end
      else if (e_op == 1) m_fp = 0;
      if (e_op == 3 && e_both) m_rr = 1 - m_rr;
      if (e_op == 3 || !e_pend) m_st = 0;
      else if (e_op == 2 && m_st < SL) m_st++;
    end
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    i_req_valid_i = 0; d_req_valid_i = 0; ptw_upd_valid_i = 0; flush_req_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 0; settle(); tick();
    rst_ni = 1;
  endtask

  typedef struct {
    bit iv, dv, pv, fr;
    bit ei, ed, ep;
    logic [31:0] eva;
  } vec_t;

  vec_t vecs[8];

  initial begin
    rst_ni = 0;
    idle_inputs();
    i_vaddr_i = '0; i_asid_i = '0; d_vaddr_i = '0; d_asid_i = '0;
    ptw_upd_i = '0; flush_asid_i = '0; flush_vaddr_i = '0;
    model_reset();
    @(negedge clk_i);

    // reset state
    settle();
    chk("reset_i_rsp_valid", 64'(i_rsp_valid_o), 64'(0));
    chk("reset_flush_done", 64'(flush_done_o), 64'(0));
    tick();
    rst_ni = 1;

    // single-cycle grant table, each vector from a fresh reset
    vecs[0] = '{1, 0, 0, 0, 1, 0, 0, 32'h1111_1000};
    vecs[1] = '{0, 1, 0, 0, 0, 1, 0, 32'h2222_2000};
    vecs[2] = '{1, 1, 0, 0, 1, 0, 0, 32'h1111_1000};
    vecs[3] = '{1, 1, 1, 0, 0, 0, 1, 32'h0};
    vecs[4] = '{0, 0, 1, 0, 0, 0, 1, 32'h0};
    vecs[5] = '{1, 1, 0, 1, 0, 0, 0, 32'h0};
    vecs[6] = '{0, 0, 0, 0, 0, 0, 0, 32'h0};
    vecs[7] = '{0, 1, 1, 0, 0, 0, 1, 32'h0};
    for (int v = 0; v < 8; v++) begin
      do_reset();
      i_vaddr_i = 32'h1111_1000; d_vaddr_i = 32'h2222_2000;
      i_req_valid_i = vecs[v].iv; d_req_valid_i = vecs[v].dv;
      ptw_upd_valid_i = vecs[v].pv; flush_req_i = vecs[v].fr;
      ptw_upd_i = {1'b0, 20'h00777, 9'd0, 32'h0000_0777};
      settle();
      chk($sformatf("vec%0d_ready", v),
          64'({i_req_ready_o, d_req_ready_o, ptw_upd_ready_o}),
          64'({vecs[v].ei, vecs[v].ed, vecs[v].ep}));
      chk($sformatf("vec%0d_vaddr", v), 64'(tlb_lu_vaddr_o), 64'(vecs[v].eva));
      tick();
      idle_inputs(); settle(); tick();
    end

    // update then I lookup hits with the written PTE
    do_reset();
    i_asid_i = 1'b1; i_vaddr_i = 32'h1234_5000;
    ptw_upd_i = {1'b0, 20'h12345, 9'd1, 32'hDEAD_BEEF}; ptw_upd_valid_i = 1;
    settle(); chk("t1_upd_ready", 64'(ptw_upd_ready_o), 64'(1)); tick();
    ptw_upd_valid_i = 0; i_req_valid_i = 1;
    settle(); chk("t1_i_grant", 64'(i_req_ready_o), 64'(1)); tick();
    i_req_valid_i = 0;
    settle();
    chk("t1_i_rsp", 64'({i_rsp_valid_o, i_rsp_hit_o, i_rsp_content_o}), 64'({1'b1, 1'b1, 32'hDEAD_BEEF}));
    tick();

    // I and D both requesting: strict alternation starting at I
    do_reset();
    i_vaddr_i = 32'h0000_1000; d_vaddr_i = 32'h0000_2000; i_asid_i = 0; d_asid_i = 0;
    i_req_valid_i = 1; d_req_valid_i = 1;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("t2_grants", 64'({i_req_ready_o, d_req_ready_o}), 64'((c % 2 == 0) ? 2'b10 : 2'b01));
      if (c > 0) chk("t2_rsp", 64'({i_rsp_valid_o, d_rsp_valid_o}), 64'((c % 2 == 1) ? 2'b10 : 2'b01));
      tick();
    end
    idle_inputs(); settle();
    chk("t2_last_rsp", 64'({i_rsp_valid_o, d_rsp_valid_o}), 64'(2'b01));
    tick();

    // flush while D requests: flush first, then D misses the flushed entry
    d_vaddr_i = 32'h1234_5000; d_asid_i = 1'b1; d_req_valid_i = 1;
    flush_req_i = 1; flush_asid_i = 0; flush_vaddr_i = 0;
    settle(); chk("t3_c0_d_ready", 64'(d_req_ready_o), 64'(0)); tick();
    flush_req_i = 0;
    settle(); chk("t3_c1_flush", 64'({tlb_flush_o, d_req_ready_o}), 64'(2'b10)); tick();
    settle(); chk("t3_c2_done_grant", 64'({flush_done_o, d_req_ready_o}), 64'(2'b11)); tick();
    d_req_valid_i = 0;
    settle(); chk("t3_c3_rsp", 64'({d_rsp_valid_o, d_rsp_hit_o}), 64'(2'b10)); tick();

    // continuous updates starve I only until the limit
    do_reset();
    ptw_upd_valid_i = 1; ptw_upd_i = {1'b0, 20'h00001, 9'd0, 32'h0000_1111};
    i_req_valid_i = 1; i_vaddr_i = 32'h0000_5000; i_asid_i = 0;
    for (int c = 0; c < 10; c++) begin
      settle();
      chk($sformatf("t4_c%0d_grants", c), 64'({i_req_ready_o, ptw_upd_ready_o}),
          64'((c == SL || c == 2 * SL + 1) ? 2'b10 : 2'b01));
      tick();
    end
    idle_inputs(); settle(); tick();

    // same-VPN update and D lookup: update first, then the lookup sees it
    do_reset();
    ptw_upd_valid_i = 1; ptw_upd_i = {1'b0, 20'h00ABC, 9'd0, 32'hCAFE_F00D};
    d_req_valid_i = 1; d_vaddr_i = 32'h00AB_C000; d_asid_i = 0;
    settle(); chk("t5_c0", 64'({ptw_upd_ready_o, d_req_ready_o}), 64'(2'b10)); tick();
    ptw_upd_valid_i = 0;
    settle(); chk("t5_c1", 64'(d_req_ready_o), 64'(1)); tick();
    d_req_valid_i = 0;
    settle();
    chk("t5_rsp", 64'({d_rsp_valid_o, d_rsp_hit_o, d_rsp_content_o}), 64'({1'b1, 1'b1, 32'hCAFE_F00D}));
    tick();

    // reset right after a lookup grant: no response ever appears
    do_reset();
    i_req_valid_i = 1; i_vaddr_i = 32'h0000_3000;
    settle(); chk("t6_grant", 64'(i_req_ready_o), 64'(1));
    rst_ni = 0;
    settle(); chk("t6_rst_outs", 64'({i_req_ready_o, tlb_lu_access_o, i_rsp_valid_o}), 64'(0)); tick();
    settle(); chk("t6_rst_hold", 64'({i_req_ready_o, tlb_lu_access_o, i_rsp_valid_o}), 64'(0)); tick();
    rst_ni = 1; i_req_valid_i = 0;
    settle(); chk("t6_post_rsp0", 64'(i_rsp_valid_o), 64'(0)); tick();
    settle(); chk("t6_post_rsp1", 64'(i_rsp_valid_o), 64'(0)); tick();

    // randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      rst_ni          = ($urandom_range(0, 149) != 0);
      i_req_valid_i   = $urandom_range(0, 1) == 1;
      d_req_valid_i   = $urandom_range(0, 1) == 1;
      ptw_upd_valid_i = $urandom_range(0, 2) == 0;
      flush_req_i     = $urandom_range(0, 24) == 0;
      i_vaddr_i       = {12'h0, 8'($urandom_range(0, 3)), 12'($urandom)};
      d_vaddr_i       = {12'h0, 8'($urandom_range(0, 3)), 12'($urandom)};
      i_asid_i        = AW'($urandom);
      d_asid_i        = AW'($urandom);
      ptw_upd_i       = {($urandom_range(0, 5) == 0), 20'($urandom_range(0, 3)), 9'($urandom), 32'($urandom)};
      flush_asid_i    = AW'($urandom);
      flush_vaddr_i   = ($urandom_range(0, 1) == 1) ? {12'h0, 8'($urandom_range(0, 3)), 12'h0} : 32'h0;
      settle();
      tick();
    end
    rst_ni = 1; idle_inputs(); settle(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tlb_access_arbiter_sv32.md
Name: tlb_access_arbiter_sv32

Overview:
- Sequences all accesses to one shared cva6_tlb_sv32 instance, which executes one operation per cycle.
- Requesters: instruction-fetch lookup port (I), load/store lookup port (D), page-table-walker update port (PTW), and the SFENCE.VMA flush request.
- Issues at most one of flush / update / lookup per cycle, registers each lookup result and returns it to the owning requester.
- Sits between the MMU front ends and the TLB.

Parameters:
- ASID_WIDTH, 1, width of the lookup and flush ASID fields; must equal the width used by the TLB.
- STARVE_LIMIT, 4, number of consecutive cycles a pending lookup may lose to updates before it is forced through.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- i_req_valid_i / d_req_valid_i  in  1  lookup request
- i_req_ready_o / d_req_ready_o  out  1  request accepted (granted) this cycle
- i_vaddr_i / d_vaddr_i  in  32  lookup virtual address
- i_asid_i / d_asid_i  in  ASID_WIDTH  lookup ASID
- i_rsp_valid_o / d_rsp_valid_o  out  1  one-cycle response strobe; no backpressure
- i_rsp_hit_o / d_rsp_hit_o  out  1  registered hit
- i_rsp_content_o / d_rsp_content_o  out  32  registered PTE
- i_rsp_is_4M_o / d_rsp_is_4M_o  out  1  registered superpage flag
- ptw_upd_valid_i  in  1  update request
- ptw_upd_ready_o  out  1  update accepted
- ptw_upd_i  in  62  {is_4M, vpn[19:0], asid[8:0], content[31:0]}
- flush_req_i  in  1  flush request pulse
- flush_asid_i  in  ASID_WIDTH  flush ASID
- flush_vaddr_i  in  32  flush vaddr
- flush_done_o  out  1  pulse after the flush has been issued
- tlb_flush_o  out  1  to TLB flush_i
- tlb_update_o  out  63  to TLB update_i; {valid, ptw_upd_i}
- tlb_lu_access_o  out  1  to TLB lu_access_i
- tlb_lu_asid_o  out  ASID_WIDTH  to TLB
- tlb_lu_vaddr_o  out  32  to TLB
- tlb_asid_to_be_flushed_o  out  ASID_WIDTH  to TLB
- tlb_vaddr_to_be_flushed_o  out  32  to TLB
- tlb_lu_content_i  in  32  from TLB
- tlb_lu_hit_i  in  1  from TLB
- tlb_lu_is_4M_i  in  1  from TLB

Behaviour:
- Reset values: all outputs 0; flush_pend = 0; rr_ptr = I; starve_cnt = 0; response registers cleared.
- Flush capture: flush_req_i sets flush_pend and latches flush_asid_i and flush_vaddr_i. A flush_req_i arriving while flush_pend is already set overwrites the latched values; flushes merge into one.
- Grant priority each cycle, combinational:
  - flush_pend first.
  - Else forced lookup, when starve_cnt == STARVE_LIMIT.
  - Else PTW update.
  - Else lookup, round-robin between I and D.
- Flush cycle:
  - tlb_flush_o = 1 and the flush fields are driven.
  - All readies are 0.
  - flush_pend clears; flush_done_o pulses the next cycle.
- Lookups are blocked while flush_pend is set, including in the cycle flush_req_i is first seen, because the flush request is registered.
- Update cycle: tlb_update_o = {1'b1, ptw_upd_i}; ptw_upd_ready_o = 1. At all other times tlb_update_o is 0.
- Lookup cycle:
  - tlb_lu_access_o = 1; vaddr and asid are muxed from the winner; winner ready = 1.
  - The TLB result is sampled at the clock edge and presented on the winner's rsp_* the following cycle with rsp_valid = 1 (latency 1).
  - rr_ptr moves to the other port only when both ports requested in that cycle.
- Starvation:
  - starve_cnt increments each cycle a lookup is pending and an update wins.
  - It resets on any lookup grant, or when no lookup is pending.
  - It saturates at STARVE_LIMIT.
- Idle cycle: all TLB-side strobes are 0 and vaddr/asid are 0.
- Simultaneous update and lookup to the same VPN: the update wins (unless the lookup is starvation-forced), so the later lookup observes the new entry.
- Reset mid-operation: any pending flush, response and counters are discarded; no rsp_valid or flush_done_o is issued after reset deasserts.

Optional Feature:
- Macro: TLB_ARB_PERF_CNT_EN.
- Defined: adds outputs perf_hit_cnt_o[31:0] and perf_miss_cnt_o[31:0]. They count registered lookup responses by hit value, wrap at 2^32, and clear on reset and on each flush issue.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- PTW update vpn=0x12345, asid=1, content=0xDEADBEEF, then I lookup vaddr=0x12345000 asid=1 -> i_rsp_valid_o the cycle after grant, hit=1, content=0xDEADBEEF.
- I and D both request every cycle for 4 cycles -> grants alternate I,D,I,D; each rsp one cycle after its grant; no double grant.
- flush_req_i asid=0 vaddr=0 while D requests -> cycle+1 tlb_flush_o=1 with d_req_ready_o=0, cycle+2 flush_done_o=1 and D granted; D lookup of the prior entry returns hit=0.
- PTW update valid continuously with I pending -> I is granted on cycle 5 (STARVE_LIMIT=4), then updates resume.
- Update and D lookup to vpn=0x00ABC in the same cycle -> update first; D granted next cycle and returns hit=1 with the new content.
- Assert rst_ni=0 in the cycle after a lookup grant -> no rsp_valid; all outputs 0 while reset is held.
